// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter
//   Shares one single-ported data memory between instruction fetch (IF) and
//   the load/store path (LS). Each accepted request becomes one req/ack memory
//   transaction; the result is returned to the requester that won arbitration.
//   LS normally wins. IF is forced through after STARVE_LIMIT consecutive LS
//   grants taken while it was waiting. An access with no mem_ack for
//   ACK_TIMEOUT cycles is aborted and reported with err.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   if_req/if_addr           IF read request (held until if_gnt)
//   if_gnt/if_rvalid         IF accept pulse / completion pulse
//   if_rdata/if_err          IF read data / timeout flag (with if_rvalid)
//   ls_req/ls_we/ls_addr     LS request (held until ls_gnt)
//   ls_wdata/ls_wstrb        LS write data / byte strobes
//   ls_gnt/ls_rvalid         LS accept pulse / completion pulse
//   ls_rdata/ls_err          LS read data (0 for writes) / timeout flag
//   mem_req..mem_wstrb       memory request, held for the whole access
//   mem_ack/mem_rdata        memory completion and read data
//   busy                     an access or its response is in progress
module mem_access_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned ACK_TIMEOUT  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_gnt,
  output logic                    if_rvalid,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  output logic                    if_err,
  input  logic                    ls_req,
  input  logic                    ls_we,
  input  logic [ADDR_WIDTH-1:0]   ls_addr,
  input  logic [DATA_WIDTH-1:0]   ls_wdata,
  input  logic [DATA_WIDTH/8-1:0] ls_wstrb,
  output logic                    ls_gnt,
  output logic                    ls_rvalid,
  output logic [DATA_WIDTH-1:0]   ls_rdata,
  output logic                    ls_err,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic                    mem_ack,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    busy
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned STARVE_W   = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned TMO_W      = $clog2(ACK_TIMEOUT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam logic [TMO_W-1:0]    TMO_MAX    = TMO_W'(ACK_TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_e;

  state_e                  state_q, state_d;
  logic [STARVE_W-1:0]     starve_q, starve_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic [TMO_W-1:0]        tmo_inc;
  logic                    owner_ls_q, owner_ls_d;
  logic                    grant_if, grant_ls;

  logic                    if_gnt_q, if_gnt_d;
  logic                    if_rvalid_q, if_rvalid_d;
  logic [DATA_WIDTH-1:0]   if_rdata_q, if_rdata_d;
  logic                    if_err_q, if_err_d;
  logic                    ls_gnt_q, ls_gnt_d;
  logic                    ls_rvalid_q, ls_rvalid_d;
  logic [DATA_WIDTH-1:0]   ls_rdata_q, ls_rdata_d;
  logic                    ls_err_q, ls_err_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic [STRB_WIDTH-1:0]   mem_wstrb_q, mem_wstrb_d;
  logic                    busy_q, busy_d;

  // Arbitration is only meaningful while no access is outstanding.
  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (state_q != ST_ACCESS) begin
      if (ls_req && !(if_req && starve_q == STARVE_MAX)) begin
        grant_ls = 1'b1;
      end else if (if_req) begin
        grant_if = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    tmo_d       = tmo_q;
    tmo_inc     = tmo_q + TMO_W'(1);
    owner_ls_d  = owner_ls_q;
    if_gnt_d    = 1'b0;
    if_rvalid_d = 1'b0;
    if_rdata_d  = '0;
    if_err_d    = 1'b0;
    ls_gnt_d    = 1'b0;
    ls_rvalid_d = 1'b0;
    ls_rdata_d  = '0;
    ls_err_d    = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;

    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (grant_ls || grant_if) begin
          state_d    = ST_ACCESS;
          tmo_d      = '0;
          owner_ls_d = grant_ls;
          mem_req_d  = 1'b1;
          if (grant_ls) begin
            ls_gnt_d    = 1'b1;
            mem_we_d    = ls_we;
            mem_addr_d  = ls_addr;
            mem_wdata_d = ls_we ? ls_wdata : '0;
            mem_wstrb_d = ls_we ? ls_wstrb : '0;
          end else begin
            if_gnt_d    = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            mem_wstrb_d = '0;
          end
        end else begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
        end
      end

      ST_ACCESS: begin
        // tmo_q counts completed ACCESS cycles without an ack.
        if (mem_ack || tmo_inc == TMO_MAX) begin
          state_d   = ST_RESP;
          mem_req_d = 1'b0;
          if (owner_ls_q) begin
            ls_rvalid_d = 1'b1;
            ls_err_d    = !mem_ack;
            ls_rdata_d  = (mem_ack && !mem_we_q) ? mem_rdata : '0;
          end else begin
            if_rvalid_d = 1'b1;
            if_err_d    = !mem_ack;
            if_rdata_d  = mem_ack ? mem_rdata : '0;
          end
        end else begin
          tmo_d = tmo_inc;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    if (!if_req || grant_if) begin
      starve_d = '0;
    end else if (grant_ls) begin
      starve_d = starve_q + STARVE_W'(1);
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      starve_q    <= '0;
      tmo_q       <= '0;
      owner_ls_q  <= 1'b0;
      if_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      if_err_q    <= 1'b0;
      ls_gnt_q    <= 1'b0;
      ls_rvalid_q <= 1'b0;
      ls_rdata_q  <= '0;
      ls_err_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      tmo_q       <= tmo_d;
      owner_ls_q  <= owner_ls_d;
      if_gnt_q    <= if_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      if_err_q    <= if_err_d;
      ls_gnt_q    <= ls_gnt_d;
      ls_rvalid_q <= ls_rvalid_d;
      ls_rdata_q  <= ls_rdata_d;
      ls_err_q    <= ls_err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      busy_q      <= busy_d;
    end
  end

  assign if_gnt    = if_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign if_err    = if_err_q;
  assign ls_gnt    = ls_gnt_q;
  assign ls_rvalid = ls_rvalid_q;
  assign ls_rdata  = ls_rdata_q;
  assign ls_err    = ls_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign busy      = busy_q;

endmodule
